// File: rtl/ex_muldiv_sched.sv
// Execute-stage scheduler for an external multi-cycle MUL/DIV/REM unit:
// detects M-extension ops, stalls the pipe, launches the unit and returns one writeback beat.
module ex_muldiv_sched #(
  parameter int WD_SIZE        = 32,
  parameter int REG_SIZE       = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                valid_i,
  input  logic [6:0]          opcode_i,
  input  logic [6:0]          funct7_i,
  input  logic [2:0]          funct3_i,
  input  logic [WD_SIZE-1:0]  rs1_data_i,
  input  logic [WD_SIZE-1:0]  rs2_data_i,
  input  logic [REG_SIZE-1:0] rd_i,
  input  logic                reg_write_i,
  input  logic                kill_i,
  output logic                mul_start_o,
  output logic [WD_SIZE-1:0]  mul_op1_o,
  output logic [WD_SIZE-1:0]  mul_op2_o,
  output logic [2:0]          mul_funct3_o,
  input  logic                mul_valid_i,
  input  logic [WD_SIZE-1:0]  mul_result_i,
  output logic                stall_proc_o,
  output logic                alu_wr_suppress_o,
  output logic                wb_valid_o,
  output logic [REG_SIZE-1:0] wb_rd_o,
  output logic [WD_SIZE-1:0]  wb_data_o,
  output logic                wb_reg_write_o,
  output logic                busy_o,
  output logic                timeout_err_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [WD_SIZE-1:0]    op1_q, op2_q, res_q;
  logic [2:0]            f3_q;
  logic [REG_SIZE-1:0]   rd_q;
  logic                  rw_q;
  logic [CW-1:0]         cnt_q;
  logic                  terr_q;
  logic                  det;
  logic                  cnt_last;

  assign det      = valid_i && (opcode_i == 7'b0110011) && (funct7_i == 7'b0000001);
  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    stall_proc_o = 1'b0;
    mul_start_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_proc_o = det && !kill_i;
        if (det && !kill_i) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        mul_start_o  = 1'b1;
        stall_proc_o = 1'b1;
        state_d      = kill_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        stall_proc_o = 1'b1;
        if (kill_i)                      state_d = S_DRAIN;
        else if (mul_valid_i || cnt_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_DRAIN: begin
        stall_proc_o = det;
        if (mul_valid_i || cnt_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter saturates so a kill on the last WAIT cycle still drains promptly.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (state_d == S_ISSUE) begin
            op1_q <= rs1_data_i;
            op2_q <= rs2_data_i;
            f3_q  <= funct3_i;
            rd_q  <= rd_i;
            rw_q  <= reg_write_i;
          end
        end
        S_ISSUE: cnt_q <= '0;
        S_WAIT: begin
          if (!kill_i && mul_valid_i) begin
            res_q <= mul_result_i;
          end else if (!kill_i && cnt_last) begin
            res_q  <= '0;
            terr_q <= 1'b1;
          end
          if (!cnt_last) cnt_q <= cnt_q + 1'b1;
        end
        S_DRAIN: begin
          if (!cnt_last) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign alu_wr_suppress_o = det;
  assign mul_op1_o         = op1_q;
  assign mul_op2_o         = op2_q;
  assign mul_funct3_o      = f3_q;
  assign wb_valid_o        = (state_q == S_DONE);
  assign wb_rd_o           = wb_valid_o ? rd_q : '0;
  assign wb_data_o         = wb_valid_o ? res_q : '0;
  assign wb_reg_write_o    = wb_valid_o && rw_q && (rd_q != '0);
  assign busy_o            = (state_q != S_IDLE);
  assign timeout_err_o     = terr_q;

endmodule

// File: tb/tb_ex_muldiv_sched.sv
// Bench for ex_muldiv_sched: directed scenarios with literal expectations, then
// randomized traffic against a transaction-level model and a behavioural M-unit.
module tb_ex_muldiv_sched;
  localparam int WD = 32;
  localparam int RW = 5;
  localparam int T  = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          valid_i = 1'b0;
  logic [6:0]    opcode_i = '0;
  logic [6:0]    funct7_i = '0;
  logic [2:0]    funct3_i = '0;
  logic [WD-1:0] rs1_data_i = '0;
  logic [WD-1:0] rs2_data_i = '0;
  logic [RW-1:0] rd_i = '0;
  logic          reg_write_i = 1'b0;
  logic          kill_i = 1'b0;
  logic          mul_valid_i = 1'b0;
  logic [WD-1:0] mul_result_i = '0;
  logic          mul_start_o, stall_proc_o, alu_wr_suppress_o, wb_valid_o;
  logic          wb_reg_write_o, busy_o, timeout_err_o;
  logic [WD-1:0] mul_op1_o, mul_op2_o, wb_data_o;
  logic [2:0]    mul_funct3_o;
  logic [RW-1:0] wb_rd_o;

  always #5 clk = ~clk;

  ex_muldiv_sched #(.WD_SIZE(WD), .REG_SIZE(RW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .opcode_i(opcode_i),
    .funct7_i(funct7_i), .funct3_i(funct3_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .rd_i(rd_i), .reg_write_i(reg_write_i), .kill_i(kill_i),
    .mul_start_o(mul_start_o), .mul_op1_o(mul_op1_o), .mul_op2_o(mul_op2_o),
    .mul_funct3_o(mul_funct3_o), .mul_valid_i(mul_valid_i), .mul_result_i(mul_result_i),
    .stall_proc_o(stall_proc_o), .alu_wr_suppress_o(alu_wr_suppress_o),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .wb_reg_write_o(wb_reg_write_o), .busy_o(busy_o), .timeout_err_o(timeout_err_o)
  );

  int checks = 0, passed = 0, cyc_n = 0, wb_count = 0;

  // Model of the scheduler's obligations: pending launch, op in flight (kept or
  // discarded) with its age, pending writeback, and the latched instruction.
  bit          m_launch, m_inflight, m_discard, m_wb, m_rw, m_terr;
  int          m_age;
  logic [31:0] m_op1, m_op2, m_res;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd;

  // Behavioural unit: counts down to a valid pulse; -1 means never answers.
  int          u_left = 0;
  logic [31:0] u_res;
  int          lat_next = 3;
  bit          spur_en = 0;
  bit          last_stall, last_kill, last_rn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  function automatic logic [31:0] muldiv(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] ss, su, uu;
    ss = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    su = {{32{a[31]}}, a} * {32'b0, b};
    uu = {32'b0, a} * {32'b0, b};
    case (f3)
      3'd0: return ss[31:0];
      3'd1: return ss[63:32];
      3'd2: return su[63:32];
      3'd3: return uu[63:32];
      3'd4: return (b == 0) ? 32'hFFFF_FFFF :
                   (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a :
                   (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic cyc(input bit v, input logic [6:0] op, input logic [6:0] f7,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input bit rw, input bit k, input bit rn);
    bit e_det, e_stall;
    @(posedge clk); #1;
    valid_i = v; opcode_i = op; funct7_i = f7; funct3_i = f3; rs1_data_i = a;
    rs2_data_i = b; rd_i = rd; reg_write_i = rw; kill_i = k; reset_n = rn;
    mul_valid_i = 1'b0; mul_result_i = $urandom;
    if (u_left > 0) begin
      u_left--;
      if (u_left == 0) begin mul_valid_i = 1'b1; mul_result_i = u_res; end
    end else if (spur_en && u_left == 0 && $urandom_range(0, 15) == 0) begin
      mul_valid_i = 1'b1;
    end
    @(negedge clk);
    cyc_n++;
    e_det = v && op == 7'b0110011 && f7 == 7'b0000001;
    if (m_launch)        e_stall = 1'b1;
    else if (m_inflight) e_stall = m_discard ? e_det : 1'b1;
    else if (m_wb)       e_stall = 1'b0;
    else                 e_stall = e_det && !k;
    chk("start",    32'(mul_start_o),       32'(m_launch));
    chk("stall",    32'(stall_proc_o),      32'(e_stall));
    chk("suppress", 32'(alu_wr_suppress_o), 32'(e_det));
    chk("wb_valid", 32'(wb_valid_o),        32'(m_wb));
    chk("busy",     32'(busy_o),            32'(m_launch || m_inflight || m_wb));
    chk("terr",     32'(timeout_err_o),     32'(m_terr));
    chk("op1",      mul_op1_o,              m_op1);
    chk("op2",      mul_op2_o,              m_op2);
    chk("funct3",   32'(mul_funct3_o),      32'(m_f3));
    if (m_wb) begin
      chk("wb_rd",   32'(wb_rd_o),        32'(m_rd));
      chk("wb_data", wb_data_o,           m_res);
      chk("wb_rw",   32'(wb_reg_write_o), 32'(m_rw && m_rd != 0));
    end
    if (wb_valid_o) wb_count++;
    if (mul_start_o) begin
      u_res  = muldiv(mul_funct3_o, mul_op1_o, mul_op2_o);
      u_left = (lat_next == 0) ? -1 : lat_next;
    end
    last_stall = e_stall; last_kill = k; last_rn = rn;
    if (!rn) begin
      m_launch = 0; m_inflight = 0; m_discard = 0; m_wb = 0; m_terr = 0; m_age = 0;
      m_op1 = 0; m_op2 = 0; m_f3 = 0; m_rd = 0; m_rw = 0; m_res = 0;
    end else if (m_launch) begin
      m_launch = 0; m_inflight = 1; m_discard = k; m_age = 0;
    end else if (m_inflight) begin
      if (!m_discard && k) begin
        m_discard = 1; m_age++;
      end else if (mul_valid_i) begin
        if (!m_discard) begin m_wb = 1; m_res = mul_result_i; end
        m_inflight = 0;
      end else if (m_age >= T - 1) begin
        if (!m_discard) begin m_wb = 1; m_res = 0; m_terr = 1; end
        m_inflight = 0;
      end else begin
        m_age++;
      end
    end else if (m_wb) begin
      m_wb = 0;
    end else if (e_det && !k) begin
      m_launch = 1; m_op1 = a; m_op2 = b; m_f3 = f3; m_rd = rd; m_rw = rw;
    end
  endtask

  task automatic idle();
    cyc(0, 7'h00, 7'h00, 3'd0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] rd, input bit k);
    cyc(1, 7'b0110011, 7'b0000001, f3, a, b, rd, 1, k, 1);
  endtask

  int w0;
  bit          c_v, c_rw;
  logic [6:0]  c_op, c_f7;
  logic [2:0]  c_f3;
  logic [31:0] c_a, c_b;
  logic [4:0]  c_rd;

  initial begin
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("rst_stall", 32'(stall_proc_o), 32'd0);
    chk("rst_busy",  32'(busy_o),       32'd0);
    chk("rst_wb",    32'(wb_valid_o),   32'd0);
    chk("rst_op1",   mul_op1_o,         32'd0);

    // MUL x5 = 7*6, unit answers 3 cycles after start
    lat_next = 3; w0 = wb_count;
    for (int i = 0; i <= 5; i++) begin
      md(3'd0, 7, 6, 5, 0);
      chk("t1_start",    32'(mul_start_o),       32'(i == 1));
      chk("t1_stall",    32'(stall_proc_o),      32'(i != 5));
      chk("t1_wb",       32'(wb_valid_o),        32'(i == 5));
      chk("t1_suppress", 32'(alu_wr_suppress_o), 32'd1);
      if (i == 5) begin
        chk("t1_rd",   32'(wb_rd_o),        32'd5);
        chk("t1_data", wb_data_o,           32'd42);
        chk("t1_rw",   32'(wb_reg_write_o), 32'd1);
      end
    end
    idle();
    chk("t1_beats", 32'(wb_count - w0), 32'd1);

    // Plain ADD is ignored
    cyc(1, 7'b0110011, 7'b0000000, 3'd0, 7, 6, 3, 1, 0, 1);
    chk("t2_stall",    32'(stall_proc_o),      32'd0);
    chk("t2_start",    32'(mul_start_o),       32'd0);
    chk("t2_suppress", 32'(alu_wr_suppress_o), 32'd0);
    idle();
    chk("t2_busy", 32'(busy_o), 32'd0);

    // Back-to-back DIVs
    lat_next = 2; w0 = wb_count;
    for (int i = 0; i <= 9; i++) begin
      if (i <= 4) md(3'd4, 100, 7, 6, 0);
      else        md(3'd4, 100, 32'hFFFF_FFF9, 7, 0);
      chk("t3_start", 32'(mul_start_o), 32'(i == 1 || i == 6));
      if (i == 4) chk("t3_data1", wb_data_o, 32'd14);
      if (i == 9) chk("t3_data2", wb_data_o, 32'hFFFF_FFF2);
    end
    idle();
    chk("t3_beats", 32'(wb_count - w0), 32'd2);

    // Kill in WAIT, new MUL held through DRAIN
    lat_next = 6; w0 = wb_count;
    for (int i = 0; i <= 16; i++) begin
      if (i <= 3) md(3'd0, 3, 5, 8, i == 3);
      else        md(3'd0, 9, 9, 9, 0);
      chk("t4_start", 32'(mul_start_o), 32'(i == 1 || i == 9));
      chk("t4_wb",    32'(wb_valid_o),  32'(i == 16));
      if (i >= 4 && i <= 7) chk("t4_hold", 32'(stall_proc_o), 32'd1);
      if (i == 16) begin
        chk("t4_data", wb_data_o,     32'd81);
        chk("t4_rd",   32'(wb_rd_o),  32'd9);
      end
    end
    idle();
    chk("t4_beats", 32'(wb_count - w0), 32'd1);

    // Unit never answers: forced completion after T WAIT cycles
    lat_next = 0;
    for (int i = 0; i <= 10; i++) begin
      md(3'd0, 2, 2, 10, 0);
      chk("t5_wb",   32'(wb_valid_o),    32'(i == 10));
      chk("t5_terr", 32'(timeout_err_o), 32'(i == 10));
      if (i == 10) chk("t5_data", wb_data_o, 32'd0);
    end
    repeat (3) idle();
    chk("t5_sticky", 32'(timeout_err_o), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("t5_cleared", 32'(timeout_err_o), 32'd0);

    // Reset in WAIT, late result must not write back
    lat_next = 5; w0 = wb_count;
    for (int i = 0; i <= 8; i++) begin
      if (i <= 2)      md(3'd0, 4, 4, 11, 0);
      else if (i == 3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      else             idle();
      if (i == 4) begin
        chk("t6_stall", 32'(stall_proc_o), 32'd0);
        chk("t6_start", 32'(mul_start_o),  32'd0);
        chk("t6_op1",   mul_op1_o,         32'd0);
        chk("t6_op2",   mul_op2_o,         32'd0);
        chk("t6_rd",    32'(wb_rd_o),      32'd0);
        chk("t6_data",  wb_data_o,         32'd0);
      end
      if (i >= 4) chk("t6_busy", 32'(busy_o), 32'd0);
    end
    chk("t6_beats", 32'(wb_count - w0), 32'd0);

    // Randomized traffic; EX holds its instruction while stalled
    spur_en = 1; last_stall = 0;
    for (int n = 0; n < 4000; n++) begin
      if (!last_stall || last_kill || !last_rn) begin
        c_v  = $urandom_range(0, 9) < 8;
        c_op = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'b0110011;
        c_f7 = ($urandom_range(0, 9) < 6) ? 7'b0000001 : 7'($urandom_range(0, 1) * 32);
        c_f3 = 3'($urandom); c_a = $urandom; c_b = $urandom;
        c_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        c_rw = $urandom_range(0, 3) != 0;
      end
      lat_next = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 10);
      cyc(c_v, c_op, c_f7, c_f3, c_a, c_b, c_rd, c_rw,
          $urandom_range(0, 19) == 0, $urandom_range(0, 149) != 0);
    end
    repeat (T + 4) idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_sched.md
Name: ex_muldiv_sched

Overview:
Scheduler that sequences an external multi-cycle M-extension unit (MUL/DIV/REM) from the execute stage. It detects MULDIV instructions at the EX inputs, freezes the pipeline, and launches the unit with a one-cycle start pulse. It waits for the unit's valid result, then returns a single writeback beat while suppressing the ALU writeback for the same instruction. It also covers flush, drain and timeout recovery.

Parameters:
WD_SIZE, 32, datapath width
REG_SIZE, 5, register index width
TIMEOUT_CYCLES, 64, max WAIT cycles before forced completion (>=2)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
valid_i  in  1  EX holds a live instruction
opcode_i  in  7  instruction opcode
funct7_i  in  7  instruction funct7
funct3_i  in  3  instruction funct3 (MUL/MULH/.../REMU select)
rs1_data_i  in  WD_SIZE  operand 1
rs2_data_i  in  WD_SIZE  operand 2
rd_i  in  REG_SIZE  destination register
reg_write_i  in  1  decode reg-write control
kill_i  in  1  flush of the EX instruction (branch/jump taken)
mul_start_o  out  1  one-cycle launch pulse to unit
mul_op1_o  out  WD_SIZE  latched operand 1
mul_op2_o  out  WD_SIZE  latched operand 2
mul_funct3_o  out  3  latched funct3
mul_valid_i  in  1  unit result valid (1-cycle pulse)
mul_result_i  in  WD_SIZE  unit result
stall_proc_o  out  1  freeze IF/ID/EX registers
alu_wr_suppress_o  out  1  EX must gate its ctrl_reg_write for this instruction
wb_valid_o  out  1  writeback beat
wb_rd_o  out  REG_SIZE  writeback destination
wb_data_o  out  WD_SIZE  writeback data
wb_reg_write_o  out  1  writeback enable
busy_o  out  1  state != IDLE
timeout_err_o  out  1  sticky timeout flag

Behaviour:
- Detection (combinational): det = valid_i & opcode_i==7'b0110011 & funct7_i==7'b0000001.
- alu_wr_suppress_o = det. It is asserted in every state.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- Reset values: state IDLE. All outputs are 0; latched operand/rd/funct3 registers are also 0. timeout_err_o is cleared only by reset.
- Reset mid-operation: return to IDLE. No start is reissued and no writeback is produced. A result still in flight is ignored.
- IDLE:
  - On det & !kill_i: latch rs1, rs2, funct3, rd, reg_write; go to ISSUE.
  - stall_proc_o = det & !kill_i, asserted in the same cycle as detection.
- ISSUE:
  - mul_start_o = 1 for exactly this cycle; stall_proc_o = 1; clear the wait counter.
  - If kill_i, go to DRAIN; otherwise go to WAIT.
  - mul_valid_i in this state is out of protocol and ignored.
- WAIT:
  - stall_proc_o = 1; the counter increments each cycle.
  - mul_valid_i: capture mul_result_i, go to DONE.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: capture 0, set timeout_err_o, go to DONE.
  - kill_i (checked before valid): go to DRAIN.
- DONE:
  - wb_valid_o = 1 for one cycle, with wb_rd_o, wb_data_o and wb_reg_write_o = latched reg_write.
  - wb_reg_write_o is forced to 0 if the latched rd == 0.
  - stall_proc_o = 0, so the finished instruction leaves EX this cycle. det is ignored for launch (it is the same instruction). Next state IDLE.
- DRAIN:
  - Waits for mul_valid_i or timeout (same counter, not reset on entry from WAIT). The result is discarded and there is no writeback.
  - stall_proc_o = det, holding any new MULDIV until the unit is free. Go to IDLE on completion; a held instruction is then launched from IDLE.
- Minimum occupancy per MULDIV:
  - detect (IDLE) -> ISSUE -> WAIT -> DONE.
  - Result at WAIT cycle k means writeback k+3 cycles after detection.
- Back-to-back MULDIVs: the second is detected in the IDLE cycle after DONE. There are no bubbles beyond the protocol.
- Operands handed to the unit are the latched values. mul_op*/mul_funct3_o stay stable from ISSUE until leaving WAIT/DRAIN.
- Division by zero and overflow semantics belong to the unit; the scheduler passes results through unchanged.

Test Plan:
- MUL x5=7*6, unit valid 3 cycles after start:
  - stall high in the detect cycle, ISSUE and WAIT.
  - start pulse in cycle 1 only.
  - wb_valid with rd=5, data=42 in cycle 5; alu_wr_suppress high throughout.
- Non-MULDIV ADD (funct7=0): no stall, no start, no wb, alu_wr_suppress=0.
- Two consecutive DIVs (100/7 then 100/-7):
  - wb data 14 then 0xFFFFFFF2.
  - second start issued the cycle after the first DONE+IDLE.
  - exactly 2 wb beats.
- kill_i asserted in WAIT, then a new MUL presented:
  - DRAIN; stall held while the new MUL waits; old result discarded.
  - new MUL launches after the unit's valid; one wb only.
- Unit never responds, TIMEOUT_CYCLES=8: DONE after 8 WAIT cycles, wb data 0, timeout_err_o=1 until reset.
- reset_n low during WAIT: all outputs 0 the next cycle, state IDLE; a late mul_valid_i produces no wb.
